vector_dot_engine: RTL



---
 rtl/vector_dot_pkg.sv | 31 +++
 rtl/floating_add_sub.sv | 71 +++++++
 rtl/floating_multiplier.sv | 45 ++++
 rtl/vector_dot_buf.sv | 40 ++++
 rtl/vector_dot_engine.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/vector_dot_pkg.sv
// Shared constants for the vector dot-product engine: register map, CTRL/STATUS
// bit positions, sequencing states and the FP zero constant.
package vector_dot_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_A_DATA = 3'd2;
    localparam logic [2:0] ADDR_B_DATA = 3'd3;
    localparam logic [2:0] ADDR_RESULT = 3'd4;
    localparam logic [2:0] ADDR_COUNT  = 3'd5;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;
    localparam int CTRL_IEN   = 2;

    localparam int ST_BUSY   = 0;
    localparam int ST_DONE   = 1;
    localparam int ST_A_FULL = 2;
    localparam int ST_B_FULL = 3;
    localparam int ST_ERR    = 4;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/floating_add_sub.sv
// Combinational IEEE-754 single-precision adder/subtractor; round to nearest
// even on the aligned sum, denormals flushed to zero.
module floating_add_sub (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] result
);
    logic [31:0] bb, xv, yv;
    logic        swap, xs, ys, guard, sticky, round_up, found;
    logic [7:0]  xe, ye, d;
    logic [26:0] xm, ym;
    logic [27:0] sum;
    logic [25:0] norm;
    logic [4:0]  sh;
    logic [9:0]  re;
    logic [22:0] frac;
    logic [30:0] rnd;

    always_comb begin
        bb   = {b[31] ^ sub, b[30:0]};
        swap = bb[30:0] > a[30:0];
        xv   = swap ? bb : a;
        yv   = swap ? a : bb;
        xs   = xv[31];
        ys   = yv[31];
        xe   = xv[30:23];
        ye   = yv[30:23];
        d    = xe - ye;
        xm   = {1'b1, xv[22:0], 3'b000};
        ym   = (d > 8'd26) ? 27'h0 : ({1'b1, yv[22:0], 3'b000} >> d);
        sum  = (xs == ys) ? ({1'b0, xm} + {1'b0, ym}) : ({1'b0, xm} - {1'b0, ym});
        sh    = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && sum[i]) begin
                sh    = 5'(26 - i);
                found = 1'b1;
            end
        end
        norm = sum[25:0] << sh;
        if (sum[27]) begin
            frac   = sum[26:4];
            guard  = sum[3];
            sticky = |sum[2:0];
            re     = {2'b0, xe} + 10'd1;
        end else begin
            frac   = norm[25:3];
            guard  = norm[2];
            sticky = |norm[1:0];
            re     = {2'b0, xe} - {5'b0, sh};
        end
        round_up = guard && (sticky || frac[0]);
        rnd      = {re[7:0], frac} + 31'(round_up);
        if (xe == 8'hFF)
            result = (xv[22:0] != 23'h0 || (ye == 8'hFF && xs != ys)) ? 32'h7FC0_0000 : xv;
        else if (xe == 8'h00)
            result = 32'h0;
        else if (ye == 8'h00)
            result = xv;
        else if (sum == 28'h0)
            result = 32'h0;
        else if (re[9] || re == 10'd0)
            result = {xs, 31'h0};
        else if (re >= 10'd255 || rnd[30:23] == 8'hFF)
            result = {xs, 8'hFF, 23'h0};
        else
            result = {xs, rnd};
    end

endmodule

// File: rtl/floating_multiplier.sv
// Combinational IEEE-754 single-precision multiplier; round to nearest even,
// denormals flushed to zero.
module floating_multiplier (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);
    logic        sign, guard, sticky, round_up;
    logic [47:0] mant_p;
    logic [9:0]  exp_s;
    logic [22:0] frac;
    logic [30:0] rnd;

    always_comb begin
        sign   = a[31] ^ b[31];
        mant_p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        exp_s  = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (mant_p[47]) begin
            frac   = mant_p[46:24];
            guard  = mant_p[23];
            sticky = |mant_p[22:0];
            exp_s  = exp_s + 10'd1;
        end else begin
            frac   = mant_p[45:23];
            guard  = mant_p[22];
            sticky = |mant_p[21:0];
        end
        round_up = guard && (sticky || frac[0]);
        rnd      = {exp_s[7:0], frac} + 31'(round_up);
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            // NaN operand or Inf*0 gives the quiet NaN
            if ((a[30:23] == 8'hFF && a[22:0] != 23'h0) || (b[30:23] == 8'hFF && b[22:0] != 23'h0) ||
                a[30:23] == 8'h00 || b[30:23] == 8'h00)
                result = 32'h7FC0_0000;
            else
                result = {sign, 8'hFF, 23'h0};
        end else if (a[30:23] == 8'h00 || b[30:23] == 8'h00 || exp_s[9] || exp_s == 10'd0)
            result = {sign, 31'h0};
        else if (exp_s >= 10'd255 || rnd[30:23] == 8'hFF)
            result = {sign, 8'hFF, 23'h0};
        else
            result = {sign, rnd};
    end

endmodule

// File: rtl/vector_dot_buf.sv
// Operand buffer: MAX_LEN x 32 storage filled by pushes at index = count,
// saturating count with full flag, combinational read port.
module vector_dot_buf
    import vector_dot_pkg::*;
#(
    parameter  int MAX_LEN = 64,
    localparam int CNT_W   = $clog2(MAX_LEN + 1),
    localparam int IDX_W   = $clog2(MAX_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             clear,
    input  logic [31:0]      push_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full
);
    logic [31:0] mem [MAX_LEN];

    assign full    = (count == CNT_W'(MAX_LEN));
    assign rd_data = mem[rd_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (push && !full)
            count <= count + CNT_W'(1);
    end

    // Storage is not reset; only the count qualifies its contents.
    always_ff @(posedge clk) begin
        if (push && !full && !clear)
            mem[count[IDX_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/vector_dot_engine.sv
// Avalon-MM single-precision dot-product engine with two-stage multiply/accumulate.
// Optional VECTOR_DOT_IRQ_EN drives irq = DONE & IEN; otherwise irq is tied low.
//
// state | meaning
// IDLE  | waiting for START, buffers accept pushes
// RUN   | issuing one element pair per cycle
// DRAIN | two cycles letting the last product reach the accumulator
// DONE  | one cycle: latch RESULT, set DONE, clear counts
module vector_dot_engine
    import vector_dot_pkg::*;
#(
    parameter int MAX_LEN = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic [31:0] writedata,
    input  logic        write,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        irq
);
    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = $clog2(MAX_LEN);

    state_t           state, state_nx;
    logic [CNT_W-1:0] idx, a_cnt, b_cnt;
    logic [31:0]      a_elem, b_elem, prod_w, sum_w, prod_q, acc, result_q, rd_mux;
    logic             prod_v, drain_q, done_q, err_q, ien_q;
    logic             wr_ctrl, wr_status, push_a_req, push_b_req, start_req, clear_req;
    logic             busy, start_ok, last_idx, a_full, b_full, cnt_clear, err_set;

    assign wr_ctrl    = write && (address == ADDR_CTRL);
    assign wr_status  = write && (address == ADDR_STATUS);
    assign push_a_req = write && (address == ADDR_A_DATA);
    assign push_b_req = write && (address == ADDR_B_DATA);
    assign clear_req  = wr_ctrl && writedata[CTRL_CLEAR];
    assign start_req  = wr_ctrl && writedata[CTRL_START] && !writedata[CTRL_CLEAR];
    assign busy       = (state != S_IDLE);
    assign start_ok   = start_req && !busy && (a_cnt == b_cnt) && (a_cnt != '0);
    assign last_idx   = (idx == a_cnt - CNT_W'(1));
    assign cnt_clear  = clear_req || (state == S_DONE);
    assign err_set    = (start_req && !busy && !start_ok) ||
                        (push_a_req && (busy || a_full)) ||
                        (push_b_req && (busy || b_full));

    vector_dot_buf #(.MAX_LEN(MAX_LEN)) u_buf_a (
        .clk(clk), .reset(reset), .push(push_a_req && !busy), .clear(cnt_clear),
        .push_data(writedata), .rd_idx(idx[IDX_W-1:0]), .rd_data(a_elem),
        .count(a_cnt), .full(a_full)
    );

    vector_dot_buf #(.MAX_LEN(MAX_LEN)) u_buf_b (
        .clk(clk), .reset(reset), .push(push_b_req && !busy), .clear(cnt_clear),
        .push_data(writedata), .rd_idx(idx[IDX_W-1:0]), .rd_data(b_elem),
        .count(b_cnt), .full(b_full)
    );

    floating_multiplier u_mul (.a(a_elem), .b(b_elem), .result(prod_w));
    floating_add_sub    u_add (.a(acc), .b(prod_q), .sub(1'b0), .result(sum_w));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start_ok) state_nx = S_RUN;
            S_RUN:   if (last_idx) state_nx = S_DRAIN;
            S_DRAIN: if (drain_q) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (clear_req)
            state_nx = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            drain_q  <= 1'b0;
            prod_v   <= 1'b0;
            prod_q   <= FP_ZERO;
            acc      <= FP_ZERO;
            result_q <= FP_ZERO;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ien_q    <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= (state == S_RUN) ? idx + CNT_W'(1) : '0;
            drain_q <= (state == S_DRAIN) && !drain_q;
            prod_v  <= (state == S_RUN) && !clear_req;
            if (state == S_RUN)
                prod_q <= prod_w;
            if (start_ok || clear_req)
                acc <= FP_ZERO;
            else if (prod_v)
                acc <= sum_w;
            if (state == S_DONE && !clear_req)
                result_q <= acc;
            if (clear_req)
                done_q <= 1'b0;
            else if (state == S_DONE)
                done_q <= 1'b1;
            else if (wr_status && writedata[ST_DONE])
                done_q <= 1'b0;
            if (err_set)
                err_q <= 1'b1;
            else if (wr_status && writedata[ST_ERR])
                err_q <= 1'b0;
            if (wr_ctrl)
                ien_q <= writedata[CTRL_IEN];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_CTRL:   rd_mux[CTRL_IEN] = ien_q;
            ADDR_STATUS: begin
                rd_mux[ST_BUSY]   = busy;
                rd_mux[ST_DONE]   = done_q;
                rd_mux[ST_A_FULL] = a_full;
                rd_mux[ST_B_FULL] = b_full;
                rd_mux[ST_ERR]    = err_q;
            end
            ADDR_RESULT: rd_mux = result_q;
            ADDR_COUNT:  rd_mux = {16'(a_cnt), 16'(b_cnt)};
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            readdata <= '0;
        else if (read)
            readdata <= rd_mux;
    end

`ifdef VECTOR_DOT_IRQ_EN
    assign irq = done_q & ien_q;
`else
    assign irq = 1'b0;
`endif

endmodule
